// File: rtl/gbuff_pkg.sv
// gbuff_pkg: shared types and width helpers for the global-buffer arbiter.
//   state_t    : arbiter state (IDLE = no owner, OWN = a requester holds the port)
//   id_width   : bits needed to name one of n requesters (owner, pointer, read tag)
//   bcnt_width : bits needed to count 0..max_burst accepts
package gbuff_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int N_REQ_DEF     = 3;
    localparam int ADDR_DEF      = 8;
    localparam int DATA_DEF      = 32;
    localparam int MAX_BURST_DEF = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bcnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/gbuff_arbiter_if.sv
// gbuff_arbiter_if: bundle between the NPU requesters / buffer and the arbiter.
//   Requester side : req, req_we, req_addr, req_wdata -> ; <- gnt, rvalid, rdata
//   Buffer side    : buf_we, buf_index, buf_din ->      ; <- buf_dout
//   master modport : the environment (requesters plus buffer instance)
//   slave modport  : the arbiter itself
interface gbuff_arbiter_if
    import gbuff_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ADDR  = ADDR_DEF,
    parameter int DATA  = DATA_DEF
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      req_we;
    logic [N_REQ*ADDR-1:0] req_addr;
    logic [N_REQ*DATA-1:0] req_wdata;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      rvalid;
    logic [DATA-1:0]       rdata;
    logic                  buf_we;
    logic [ADDR-1:0]       buf_index;
    logic [DATA-1:0]       buf_din;
    logic [DATA-1:0]       buf_dout;

    modport master (
        output req, req_we, req_addr, req_wdata, buf_dout,
        input  gnt, rvalid, rdata, buf_we, buf_index, buf_din
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, buf_dout,
        output gnt, rvalid, rdata, buf_we, buf_index, buf_din
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req : request vector, one bit per requester
//   ptr : highest-priority index; search runs ptr, ptr+1, ... wrapping modulo N
//   gnt : one-hot grant of the first requesting index found
//   idx : encoded form of gnt
//   any : at least one request was present
module rr_pick
    import gbuff_pkg::*;
#(
    parameter int N    = N_REQ_DEF,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                       = 1'b1;
                gnt[(int'(ptr) + k) % N]  = 1'b1;
                idx                       = ID_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/gbuff_arbiter.sv
// gbuff_arbiter: round-robin, burst-bounded arbiter sharing one global-buffer
// port between N_REQ requesters. Everything is on the rising edge; the buffer
// itself samples on the falling edge of the cycle after an accept.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : gbuff_arbiter_if.slave
//          req/req_we/req_addr/req_wdata in, gnt out (combinational)
//          rvalid/rdata out (registered, one cycle after a read accept)
//          buf_we/buf_index/buf_din out (registered), buf_dout in
module gbuff_arbiter
    import gbuff_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int ADDR      = ADDR_DEF,
    parameter int DATA      = DATA_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    gbuff_arbiter_if.slave bus
);

    localparam int ID_W = id_width(N_REQ);
    localparam int BC_W = bcnt_width(MAX_BURST);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   own_q, own_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;

    logic [ID_W-1:0]   pick_ptr;
    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;

    logic              own_cont;
    logic [N_REQ-1:0]  gnt_c;
    logic              xfer;
    logic [ID_W-1:0]   xfer_id;
    logic              sel_we;
    logic [ADDR-1:0]   sel_addr;
    logic [DATA-1:0]   sel_wdata;

    logic              pend_vld_p1;
    logic [ID_W-1:0]   pend_id_p1;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
        return (int'(x) == N_REQ - 1) ? '0 : x + ID_W'(1);
    endfunction

    // The owner keeps the port while it still requests and has burst budget left.
    assign own_cont = (state_q == OWN) && bus.req[own_q] &&
                      (bcnt_q < BC_W'(MAX_BURST));

    // On release the search restarts just past the old owner, in the same
    // cycle, so a hand-over costs no bubble.
    assign pick_ptr = (state_q == OWN) ? next_id(own_q) : ptr_q;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        gnt_c   = '0;
        xfer    = 1'b0;
        xfer_id = pick_idx;
        if (own_cont) begin
            gnt_c   = N_REQ'(1) << own_q;
            xfer    = 1'b1;
            xfer_id = own_q;
            bcnt_d  = bcnt_q + BC_W'(1);
        end else begin
            if (state_q == OWN) begin
                ptr_d = next_id(own_q);
            end
            if (pick_any) begin
                gnt_c   = pick_gnt;
                xfer    = 1'b1;
                state_d = OWN;
                own_d   = pick_idx;
                bcnt_d  = BC_W'(1);
            end else begin
                state_d = IDLE;
                bcnt_d  = '0;
            end
        end
        if (!rst) begin
            gnt_c = '0;
            xfer  = 1'b0;
        end
    end

    assign bus.gnt   = gnt_c;
    assign sel_we    = bus.req_we[xfer_id];
    assign sel_addr  = bus.req_addr[int'(xfer_id)*ADDR +: ADDR];
    assign sel_wdata = bus.req_wdata[int'(xfer_id)*DATA +: DATA];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Stage p0 -> p1: accepted request onto the buffer pins, read tag captured.
    // Stage p1 -> p2: buffer read data returned to the tagged requester.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.buf_we    <= 1'b0;
            bus.buf_index <= '0;
            bus.buf_din   <= '0;
            pend_vld_p1   <= 1'b0;
            pend_id_p1    <= '0;
            bus.rvalid    <= '0;
            bus.rdata     <= '0;
        end else begin
            bus.buf_we  <= xfer && sel_we;
            if (xfer) begin
                bus.buf_index <= sel_addr;
                bus.buf_din   <= sel_wdata;
            end
            pend_vld_p1 <= xfer && !sel_we;
            pend_id_p1  <= xfer_id;
            bus.rvalid  <= pend_vld_p1 ? (N_REQ'(1) << pend_id_p1) : '0;
            if (pend_vld_p1) begin
                bus.rdata <= bus.buf_dout;
            end
        end
    end

endmodule

// File: tb/tb_gbuff_arbiter.sv
// tb_gbuff_arbiter: table-driven directed vectors, hand sequences for the
// multi-cycle corners, then randomized traffic against a reference model.
module tb_gbuff_arbiter;

    localparam int N  = 3;
    localparam int A  = 8;
    localparam int D  = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gbuff_arbiter_if #(.N_REQ(N), .ADDR(A), .DATA(D)) bus ();

    gbuff_arbiter #(.N_REQ(N), .ADDR(A), .DATA(D), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
    endfunction

    // Buffer instance model: acts on the falling edge.
    logic [31:0] mem [256];
    bit          mem_init = 1'b0;
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            mem_init = 1'b1;
        end
        if (bus.buf_we) mem[bus.buf_index] = bus.buf_din;
        bus.buf_dout <= mem[bus.buf_index];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive_all(input logic rn, input logic [N-1:0] r, input logic [N-1:0] we,
                             input logic [A-1:0] addr, input logic [D-1:0] wd);
        rst        = rn;
        bus.req    = r;
        bus.req_we = we;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*A +: A]  = addr;
            bus.req_wdata[i*D +: D] = wd;
        end
    endtask

    typedef struct {
        logic          rn;
        logic [N-1:0]  req;
        logic [N-1:0]  we;
        logic [A-1:0]  addr;
        logic [D-1:0]  wd;
        logic [N-1:0]  gnt;
        logic [N-1:0]  rv;
        logic [D-1:0]  rd;
        logic          bwe;
        logic [A-1:0]  bidx;
    } vec_t;

    function automatic vec_t mk(input logic rn, input logic [N-1:0] req, input logic [N-1:0] we,
                                input logic [A-1:0] addr, input logic [D-1:0] wd,
                                input logic [N-1:0] gnt, input logic [N-1:0] rv,
                                input logic [D-1:0] rd, input logic bwe, input logic [A-1:0] bidx);
        vec_t v;
        v.rn = rn; v.req = req; v.we = we; v.addr = addr; v.wd = wd;
        v.gnt = gnt; v.rv = rv; v.rd = rd; v.bwe = bwe; v.bidx = bidx;
        return v;
    endfunction

    localparam int NV = 37;
    vec_t vt [NV];

    // Reference model state: integers, -1 meaning no owner.
    int          m_owner, m_cnt, m_ptr;
    logic [31:0] ref_mem [256];

    function automatic int model_pick(input logic [N-1:0] r);
        int start;
        if (m_owner >= 0 && r[m_owner] && m_cnt < MB) return m_owner;
        start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
        for (int k = 0; k < N; k++) if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return (i >= 0) ? (N'(1) << i) : '0;
    endfunction

    logic [N-1:0] rreq;
    logic [N-1:0] rwe;
    logic [A-1:0] raddr [N];
    logic [D-1:0] rwd   [N];
    int           waitc [N];

    logic [N-1:0] exp_rv, pend_rv;
    logic [D-1:0] exp_rd, pend_rd, exp_bdin;
    logic         exp_bwe;
    logic [A-1:0] exp_bidx;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        vt[0]  = mk(1, 3'b001, 3'b000, 8'd5, 32'h0,        3'b001, 3'b000, 32'h0,        0, 8'd0);
        vt[1]  = mk(1, 3'b000, 3'b000, 8'd5, 32'h0,        3'b000, 3'b000, 32'h0,        0, 8'd5);
        vt[2]  = mk(1, 3'b000, 3'b000, 8'd5, 32'h0,        3'b000, 3'b001, 32'hDEADBEEF, 0, 8'd5);
        vt[3]  = mk(1, 3'b010, 3'b010, 8'd9, 32'h12345678, 3'b010, 3'b000, 32'h0,        0, 8'd5);
        vt[4]  = mk(1, 3'b010, 3'b000, 8'd9, 32'h0,        3'b010, 3'b000, 32'h0,        1, 8'd9);
        vt[5]  = mk(1, 3'b000, 3'b000, 8'd9, 32'h0,        3'b000, 3'b000, 32'h0,        0, 8'd9);
        vt[6]  = mk(1, 3'b000, 3'b000, 8'd9, 32'h0,        3'b000, 3'b010, 32'h12345678, 0, 8'd9);
        vt[7]  = mk(0, 3'b111, 3'b000, 8'd1, 32'h0,        3'b000, 3'b000, 32'h0,        0, 8'd9);
        vt[8]  = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b001, 3'b000, 32'h0,        0, 8'd0);
        vt[9]  = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b001, 3'b000, 32'h0,        0, 8'd1);
        vt[10] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b001, 3'b001, 32'hA0000001, 0, 8'd1);
        vt[11] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b001, 3'b001, 32'hA0000001, 0, 8'd1);
        vt[12] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b010, 3'b001, 32'hA0000001, 0, 8'd1);
        vt[13] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b010, 3'b001, 32'hA0000001, 0, 8'd1);
        vt[14] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b010, 3'b010, 32'hA0000001, 0, 8'd1);
        vt[15] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b010, 3'b010, 32'hA0000001, 0, 8'd1);
        vt[16] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b100, 3'b010, 32'hA0000001, 0, 8'd1);
        vt[17] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b100, 3'b010, 32'hA0000001, 0, 8'd1);
        vt[18] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b100, 3'b100, 32'hA0000001, 0, 8'd1);
        vt[19] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b100, 3'b100, 32'hA0000001, 0, 8'd1);
        vt[20] = mk(1, 3'b111, 3'b000, 8'd1, 32'h0,        3'b001, 3'b100, 32'hA0000001, 0, 8'd1);
        vt[21] = mk(1, 3'b000, 3'b000, 8'd1, 32'h0,        3'b000, 3'b100, 32'hA0000001, 0, 8'd1);
        vt[22] = mk(1, 3'b000, 3'b000, 8'd1, 32'h0,        3'b000, 3'b001, 32'hA0000001, 0, 8'd1);
        vt[23] = mk(1, 3'b000, 3'b000, 8'd1, 32'h0,        3'b000, 3'b000, 32'h0,        0, 8'd1);
        vt[24] = mk(0, 3'b000, 3'b000, 8'd2, 32'h0,        3'b000, 3'b000, 32'h0,        0, 8'd1);
        vt[25] = mk(1, 3'b101, 3'b000, 8'd2, 32'h0,        3'b001, 3'b000, 32'h0,        0, 8'd0);
        vt[26] = mk(1, 3'b101, 3'b000, 8'd2, 32'h0,        3'b001, 3'b000, 32'h0,        0, 8'd2);
        vt[27] = mk(1, 3'b100, 3'b000, 8'd2, 32'h0,        3'b100, 3'b001, 32'hA0000002, 0, 8'd2);
        vt[28] = mk(1, 3'b100, 3'b000, 8'd2, 32'h0,        3'b100, 3'b001, 32'hA0000002, 0, 8'd2);
        vt[29] = mk(1, 3'b000, 3'b000, 8'd2, 32'h0,        3'b000, 3'b100, 32'hA0000002, 0, 8'd2);
        vt[30] = mk(1, 3'b000, 3'b000, 8'd2, 32'h0,        3'b000, 3'b100, 32'hA0000002, 0, 8'd2);
        vt[31] = mk(0, 3'b000, 3'b000, 8'd3, 32'h0,        3'b000, 3'b000, 32'h0,        0, 8'd2);
        vt[32] = mk(1, 3'b101, 3'b000, 8'd3, 32'h0,        3'b001, 3'b000, 32'h0,        0, 8'd0);
        vt[33] = mk(1, 3'b101, 3'b000, 8'd3, 32'h0,        3'b001, 3'b000, 32'h0,        0, 8'd3);
        vt[34] = mk(1, 3'b110, 3'b000, 8'd3, 32'h0,        3'b010, 3'b001, 32'hA0000003, 0, 8'd3);
        vt[35] = mk(1, 3'b000, 3'b000, 8'd3, 32'h0,        3'b000, 3'b001, 32'hA0000003, 0, 8'd3);
        vt[36] = mk(1, 3'b000, 3'b000, 8'd3, 32'h0,        3'b000, 3'b010, 32'hA0000003, 0, 8'd3);

        // Reset state, with every requester asserting.
        drive_all(0, 3'b000, 3'b000, 8'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        drive_all(0, 3'b111, 3'b000, 8'd7, 32'h0);
        @(negedge clk);
        chk("reset gnt", 32'(bus.gnt), 32'h0);
        chk("reset rvalid", 32'(bus.rvalid), 32'h0);
        chk("reset rdata", bus.rdata, 32'h0);
        chk("reset buf_we", 32'(bus.buf_we), 32'h0);
        chk("reset buf_index", 32'(bus.buf_index), 32'h0);
        chk("reset buf_din", bus.buf_din, 32'h0);
        @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) begin
            drive_all(vt[k].rn, vt[k].req, vt[k].we, vt[k].addr, vt[k].wd);
            @(negedge clk);
            chk($sformatf("vec%0d gnt", k), 32'(bus.gnt), 32'(vt[k].gnt));
            chk($sformatf("vec%0d rvalid", k), 32'(bus.rvalid), 32'(vt[k].rv));
            if (vt[k].rv != '0) chk($sformatf("vec%0d rdata", k), bus.rdata, vt[k].rd);
            chk($sformatf("vec%0d buf_we", k), 32'(bus.buf_we), 32'(vt[k].bwe));
            chk($sformatf("vec%0d buf_index", k), 32'(bus.buf_index), 32'(vt[k].bidx));
            @(posedge clk);
            #1;
        end

        // Lone requester: ten back-to-back reads, no bubble across burst wraps.
        drive_all(0, 3'b000, 3'b000, 8'd4, 32'h0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 12; k++) begin
            drive_all(1, (k < 10) ? 3'b010 : 3'b000, 3'b000, 8'd4, 32'h0);
            @(negedge clk);
            chk($sformatf("lone%0d gnt", k), 32'(bus.gnt), (k < 10) ? 32'h2 : 32'h0);
            if (k >= 2) begin
                chk($sformatf("lone%0d rvalid", k), 32'(bus.rvalid), 32'h2);
                chk($sformatf("lone%0d rdata", k), bus.rdata, 32'hA0000004);
            end
            @(posedge clk);
            #1;
        end

        // Reset on the edge right after a read accept.
        drive_all(0, 3'b000, 3'b000, 8'd5, 32'h0);
        @(posedge clk);
        #1;
        drive_all(1, 3'b001, 3'b000, 8'd5, 32'h0);
        @(negedge clk);
        chk("rstmid accept gnt", 32'(bus.gnt), 32'h1);
        @(posedge clk);
        #1;
        drive_all(0, 3'b000, 3'b000, 8'd5, 32'h0);
        @(negedge clk);
        chk("rstmid gnt in reset", 32'(bus.gnt), 32'h0);
        @(posedge clk);
        #1;
        drive_all(1, 3'b111, 3'b000, 8'd6, 32'h0);
        @(negedge clk);
        chk("rstmid rvalid", 32'(bus.rvalid), 32'h0);
        chk("rstmid rdata", bus.rdata, 32'h0);
        chk("rstmid buf_we", 32'(bus.buf_we), 32'h0);
        chk("rstmid buf_index", 32'(bus.buf_index), 32'h0);
        chk("rstmid buf_din", bus.buf_din, 32'h0);
        chk("rstmid next gnt", 32'(bus.gnt), 32'h1);
        @(posedge clk);
        #1;
        drive_all(1, 3'b000, 3'b000, 8'd6, 32'h0);
        @(negedge clk);
        chk("rstmid no late rvalid", 32'(bus.rvalid), 32'h0);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        drive_all(0, 3'b000, 3'b000, 8'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        m_owner = -1; m_cnt = 0; m_ptr = 0;
        exp_rv = '0; exp_rd = '0; pend_rv = '0; pend_rd = '0;
        exp_bwe = 1'b0; exp_bidx = '0; exp_bdin = '0;
        rreq = '0; rwe = '0;
        for (int i = 0; i < N; i++) begin
            raddr[i] = '0; rwd[i] = '0; waitc[i] = 0;
        end
        rst = 1'b1;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            int  w;
            bit  cont;
            for (int i = 0; i < N; i++) begin
                if (!rreq[i] && $urandom_range(0, 9) < 6) begin
                    rreq[i]  = 1'b1;
                    rwe[i]   = ($urandom_range(0, 2) == 0);
                    raddr[i] = A'($urandom_range(16, 31));
                    rwd[i]   = $urandom;
                    waitc[i] = 0;
                end
                bus.req[i]              = rreq[i];
                bus.req_we[i]           = rwe[i];
                bus.req_addr[i*A +: A]  = raddr[i];
                bus.req_wdata[i*D +: D] = rwd[i];
            end
            cont = (m_owner >= 0) && rreq[m_owner] && (m_cnt < MB);
            w    = model_pick(rreq);

            @(negedge clk);
            chk($sformatf("rnd%0d gnt", cyc), 32'(bus.gnt), 32'(oh(w)));
            chk($sformatf("rnd%0d rvalid", cyc), 32'(bus.rvalid), 32'(exp_rv));
            chk($sformatf("rnd%0d rdata", cyc), bus.rdata, exp_rd);
            chk($sformatf("rnd%0d buf_we", cyc), 32'(bus.buf_we), 32'(exp_bwe));
            chk($sformatf("rnd%0d buf_index", cyc), 32'(bus.buf_index), 32'(exp_bidx));
            chk($sformatf("rnd%0d buf_din", cyc), bus.buf_din, exp_bdin);
            @(posedge clk);

            exp_rv = pend_rv;
            if (pend_rv != '0) exp_rd = pend_rd;
            if (w >= 0) begin
                exp_bwe  = rwe[w];
                exp_bidx = raddr[w];
                exp_bdin = rwd[w];
                if (rwe[w]) begin
                    ref_mem[raddr[w]] = rwd[w];
                    pend_rv = '0;
                end else begin
                    pend_rv = oh(w);
                    pend_rd = ref_mem[raddr[w]];
                end
                chk($sformatf("rnd%0d wait bound req%0d", cyc, w),
                    32'(waitc[w] > (N - 1) * MB), 32'h0);
                for (int j = 0; j < N; j++) if (j != w && rreq[j]) waitc[j]++;
                rreq[w] = 1'b0;
            end else begin
                exp_bwe = 1'b0;
                pend_rv = '0;
            end
            if (cont) begin
                m_cnt++;
            end else begin
                if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
                if (w >= 0) begin
                    m_owner = w;
                    m_cnt   = 1;
                end else begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gbuff_arbiter.md
# gbuff_arbiter

Round-robin arbiter with bounded bursts that shares one global-buffer port between `N_REQ` NPU requesters, such as the weight loader, activation writer and PE-array reader. It sits between the requesters and the buffer instance. It registers the winning request onto the buffer's `we`/`index`/`din` pins and routes the buffer's `dout` back to the requester that issued the read. The buffer acts on the falling clock edge; this block works entirely on the rising edge.

## Interface
- `N_REQ`, 3: number of requesters, 2..8
- `ADDR`, 8: buffer index width; must match the buffer instance
- `DATA`, 32: word width; must match the buffer instance
- `MAX_BURST`, 4: maximum consecutive accepts for one owner before rotation, ≥1
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, synchronous, active-low
- `req` in N_REQ: request valid, one bit per requester
- `req_we` in N_REQ: 1 = write, 0 = read, per requester
- `req_addr` in N_REQ*ADDR: requester i uses `[i*ADDR +: ADDR]`
- `req_wdata` in N_REQ*DATA: requester i uses `[i*DATA +: DATA]`
- `gnt` out N_REQ: combinational, at most one bit high
- `rvalid` out N_REQ: registered, one-hot read-return strobe
- `rdata` out DATA: registered, shared read-return data
- `buf_we` out 1: to buffer `we`
- `buf_index` out ADDR: to buffer `index`
- `buf_din` out DATA: to buffer `din`
- `buf_dout` in DATA: from buffer `dout`

## Operation
- **Handshake:** valid/ready. A transfer for requester i occurs at a rising edge where `req[i] & gnt[i]`. The requester holds `req_we`, `req_addr` and `req_wdata` stable while `req[i]` is high and `gnt[i]` is low.
- **States:** `IDLE` (no owner) and `OWN` (owner `own`, burst count `bcnt`).
- **IDLE:** `gnt` goes to the first requester with `req` high, searching from `ptr` upward and wrapping modulo N_REQ. On transfer: go to `OWN`, set `own` = i, `bcnt` = 1.
- **OWN, owner requesting and `bcnt` < MAX_BURST:** `gnt[own]` stays high. On transfer, `bcnt`++.
- **OWN, owner drops `req` or `bcnt` = MAX_BURST:** set `ptr` = own+1 (mod N_REQ). Arbitrate in the same cycle as IDLE using the new `ptr`, so there is no bubble. If only the owner is requesting, it wins again with `bcnt` = 1.
- **OWN, no requester has `req` high:** go to `IDLE`.
- **Transfer outputs:** on a transfer, the next cycle's `buf_we`, `buf_index` and `buf_din` take requester i's `req_we`, `req_addr` and `req_wdata`.
- **No transfer:** the next cycle has `buf_we` = 0. `buf_index` and `buf_din` hold their previous values; the buffer then performs a harmless read.
- **Read tracking:** a read transfer sets a pending tag (valid bit plus id i) for one cycle. At the following edge, `rdata` ← `buf_dout` and `rvalid[id]` = 1 for exactly one cycle.
- **Write transfers** never raise `rvalid`. `rdata` holds its last value when `rvalid` is 0.
- **Back-to-back reads:** one read per cycle. Returns arrive in issue order, each exactly one cycle after its accept.
- **Simultaneous requests:** lowest index at or after `ptr` wins. No requester waits more than (N_REQ−1)·MAX_BURST accepts.
- **Reset:** while `rst` = 0, `gnt` = 0. At a reset edge:
  - `rvalid` = 0, `rdata` = 0
  - `buf_we` = 0, `buf_index` = 0, `buf_din` = 0
  - state = `IDLE`, `ptr` = 0, `bcnt` = 0, pending tag cleared
- **Reset mid-burst:** an accepted read still in flight produces no `rvalid`.

## Timing
- Accept edge E0 drives `buf_*` for the E0–E1 cycle.
- The buffer accesses the array at the falling edge inside that cycle.
- `rvalid`/`rdata` are visible in the E1–E2 cycle, so read latency is 1 cycle after accept.
- A write lands in the array half a cycle after E0 + 1.
- `gnt` depends combinationally on `req`, state, `ptr` and `bcnt`. It has no path from `buf_dout`.
- Sustained throughput: 1 access per cycle.

## Structure
- Package `gbuff_pkg`:
  - state enum `{IDLE, OWN}`
  - `clog2`-derived id width for `own`, `ptr` and the pending tag
  - burst-counter width, `$clog2(MAX_BURST+1)`
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs: `req` vector and `ptr`. Outputs: one-hot grant and encoded index. It is instantiated once.

## Test plan
- **Single read:** after reset, req0 reads index 5 holding 0xDEADBEEF. Expect `gnt[0]` at E0, `buf_index` = 5 / `buf_we` = 0 in the next cycle, `rvalid` = 3'b001 and `rdata` = 0xDEADBEEF one cycle after accept.
- **Write then read:** req1 writes 0x12345678 to index 9, then reads index 9. Expect `rvalid[1]` with 0x12345678 and no `rvalid` on the write.
- **Burst rotation:** MAX_BURST = 4, all three requesters constantly request. Expect grants 0,0,0,0,1,1,1,1,2,2,2,2,0 with no idle cycle.
- **Early release:** req0 drops after 2 accepts while req2 is waiting. Expect `gnt[2]` in the cycle req0 drops; `ptr` becomes 1, so req1 would have won had it been requesting.
- **Lone requester:** only req1 requests for 10 cycles. Expect 10 consecutive accepts with `bcnt` wrapping 1..4 and no bubble.
- **Reset mid-read:** `rst` = 0 on the edge after a read accept. Expect no `rvalid`, all outputs zero, and the next arbitration starting from requester 0.
